pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). The pipeline has no forwarding, so this block keeps a destination-register scoreboard of in-flight writers. It stalls IF/ID on read-after-write hazards and injects EX bubbles. It also flushes younger stages when a branch resolves taken in MEM (PC_Src).

Parameters:
REG_AW, 5, register address width
SB_DEPTH, 4, scoreboard entries: EX, MEM, WB, RFW (the register-file write cycle after WB)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  pipeline clock
res  in  1  asynchronous reset, active-high
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_AW  source 1 address
id_rs2  in  REG_AW  source 2 address
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  destination address
id_reg_write  in  1  instruction writes rd
br_taken  in  1  taken branch resolved in MEM (PC_Src)
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
bubble_ex  out  1  load NOP controls into ID/EX
flush_if_id  out  1  kill the instruction entering ID
flush_id_ex  out  1  kill the instruction entering EX
flush_ex_mem  out  1  kill the instruction entering MEM
ctrl_state  out  2  0=RUN, 1=STALL, 2=FLUSH
stall_cnt  out  CNT_W  total stall cycles
flush_cnt  out  CNT_W  total taken-branch flushes

Behaviour:
- Interface: one clock, clk. res is asynchronous and active-high. While res is high, all registers clear: scoreboard invalid, ctrl_state=RUN, both counters 0. All outputs read 0.
- Scoreboard: SB_DEPTH entries of {valid, rd}. Entry 0 is EX; the last entry is RFW. It shifts every clk edge and never holds.
- Entry 0 load: loads {1, id_rd} only when id_valid & id_reg_write & id_rd!=0 & no hazard & no br_taken. Otherwise it loads invalid (a bubble).
- Hazard, combinational: id_valid & ((id_use_rs1 & id_rs1!=0 & id_rs1 matches any valid entry) | (same for rs2)).
- Stall outputs: stall_if = stall_id = bubble_ex = hazard & ~br_taken. These are combinational, with zero-cycle latency from the inputs.
- Register-file timing: the register file writes at the end of the RFW cycle. A dependent instruction that is one cycle behind its producer therefore stalls exactly SB_DEPTH cycles.
- Flush: when br_taken is high, flush_if_id, flush_id_ex and flush_ex_mem are all high in that same cycle. Entry 0 and the current EX entry are cleared at the clock edge, since both hold instructions younger than the branch. MEM and older entries shift normally.
- Priority: br_taken beats hazard. During a flush no stall is asserted and stall_cnt does not increment.
- ctrl_state, registered:
  - RUN->STALL on hazard; STALL->RUN when hazard clears.
  - Any state -> FLUSH on br_taken.
  - FLUSH->RUN, or FLUSH->STALL if hazard, on the next edge. FLUSH lasts one cycle unless br_taken repeats.
- Counters:
  - stall_cnt increments on each edge where stall_id=1.
  - flush_cnt increments on each edge where br_taken=1.
  - Both saturate at all-ones; they never wrap.
- Boundaries:
  - id_valid=0 gives no stall.
  - rd=x0 is never tracked.
  - rs1 and rs2 both matching still counts as one stall per cycle.
  - Back-to-back br_taken flushes each cycle and counts each one.
  - res asserted mid-stall drops all outputs immediately, without waiting for a clock edge.

Decomposition:
- Shared package: ctrl_state encoding (ST_RUN, ST_STALL, ST_FLUSH), REG_AW, and the NOP control-word constant used by bubble_ex consumers.
- One natural sub-module: hazard_scoreboard, holding the shift register plus the rs1/rs2 match logic and exposing a hazard output.
- The FSM, flush logic and counters stay in the top-level module.

Test Plan:
1. Reset: res=1 mid-simulation, no clock edge -> every output 0 and ctrl_state=0 immediately. After release, id_valid=0 for 5 cycles -> no stall, counters stay 0.
2. RAW hazard: addi x5 (rd=5, reg_write=1) issued, then add x6,x5,x0 (rs1=5) in ID on the next cycle -> stall_id=1 for exactly 4 cycles, released on the 5th; stall_cnt=4; ctrl_state RUN->STALL->RUN.
3. x0 producer: rd=0 with reg_write=1, then a consumer with rs1=0 -> stall_id never asserted, stall_cnt=0.
4. Branch plus hazard: hazard pending and br_taken=1 in the same cycle -> all three flush outputs 1, stall_id=0, flush_cnt=1, ctrl_state=FLUSH for one cycle. A later read of the flushed rd does not stall.
5. Saturation: CNT_W=4, hazard held for 20 cycles -> stall_cnt holds at 15.
6. Double source: rs1=7, rs2=7, one valid entry with rd=7 in MEM -> stall lasts 3 cycles (MEM, WB, RFW), stall_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Holds the controller state encoding and the NOP control word that bubble_ex consumers load.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW   = 5;
    localparam int SB_DEPTH = 4;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_to_reg;
    } ctrl_word_t;

    // An all-zero control word performs no architectural side effect.
    localparam ctrl_word_t NOP_CTRL = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Destination-register scoreboard of in-flight writers (EX, MEM, WB, RFW).
// Shifts every cycle and flags a read-after-write hazard for the instruction in ID.
module hazard_scoreboard #(
    parameter int REG_AW   = pipeline_hazard_ctrl_pkg::REG_AW,
    parameter int SB_DEPTH = pipeline_hazard_ctrl_pkg::SB_DEPTH
) (
    input  logic              clk,
    input  logic              res,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_use_rs1,
    input  logic              i_use_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_reg_write,
    input  logic              i_flush,
    output logic              o_hazard
);
    import pipeline_hazard_ctrl_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
    } sb_entry_t;

    sb_entry_t r_sb [SB_DEPTH];

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_hazard;
    logic w_load;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (r_sb[i].valid && (r_sb[i].rd == i_rs1)) w_rs1_hit = 1'b1;
            if (r_sb[i].valid && (r_sb[i].rd == i_rs2)) w_rs2_hit = 1'b1;
        end
    end

    assign w_hazard = i_id_valid &
                      ((i_use_rs1 & (i_rs1 != '0) & w_rs1_hit) |
                       (i_use_rs2 & (i_rs2 != '0) & w_rs2_hit));
    assign o_hazard = w_hazard;

    // x0 is hardwired, so writes to it never need tracking.
    assign w_load = i_id_valid & i_reg_write & (i_rd != '0) & ~w_hazard & ~i_flush;

    // NOTE: the scoreboard is a control structure, so every entry is reset;
    // stale valid bits after reset would raise phantom hazards.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < SB_DEPTH; i++) r_sb[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every entry shift from its pre-edge value.
            r_sb[0] <= w_load ? '{valid: 1'b1, rd: i_rd} : '0;
            // The instruction leaving EX is younger than the taken branch in MEM.
            r_sb[1] <= i_flush ? '0 : r_sb[0];
            for (int i = 2; i < SB_DEPTH; i++) r_sb[i] <= r_sb[i-1];
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline without forwarding.
// Stalls on RAW hazards, flushes younger stages on a taken branch, counts both events.
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = pipeline_hazard_ctrl_pkg::REG_AW,
    parameter int SB_DEPTH = pipeline_hazard_ctrl_pkg::SB_DEPTH,
    parameter int CNT_W    = pipeline_hazard_ctrl_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              res,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              br_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             w_hazard;
    logic             w_stall;
    logic             w_flush;
    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .res         (res),
        .i_id_valid  (id_valid),
        .i_rs1       (id_rs1),
        .i_rs2       (id_rs2),
        .i_use_rs1   (id_use_rs1),
        .i_use_rs2   (id_use_rs2),
        .i_rd        (id_rd),
        .i_reg_write (id_reg_write),
        .i_flush     (br_taken),
        .o_hazard    (w_hazard)
    );

    // Every state leaves by the same priority: branch flush first, then hazard stall.
    always_comb begin
        w_state_nxt = ST_RUN;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        if (!res) begin
            if (br_taken) begin
                w_state_nxt = ST_FLUSH;
                w_flush     = 1'b1;
            end else if (w_hazard) begin
                w_state_nxt = ST_STALL;
                w_stall     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_if     = w_stall;
    assign stall_id     = w_stall;
    assign bubble_ex    = w_stall;
    assign flush_if_id  = w_flush;
    assign flush_id_ex  = w_flush;
    assign flush_ex_mem = w_flush;
    assign ctrl_state   = r_state;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
